// File: rtl/line_burst_adaptor_if.sv
// Line-request / burst-memory bundle for line_burst_adaptor.
// slave: the adaptor's view. master: the requester plus burst-memory side.
interface line_burst_adaptor_if #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64
);
    localparam int unsigned LineW = BEATS * BEAT_W;

    logic              line_read_i;
    logic              line_write_i;
    logic [31:0]       line_addr_i;
    logic [LineW-1:0]  line_wdata_i;
    logic [LineW-1:0]  line_rdata_o;
    logic              line_resp_o;
    logic              burst_read_o;
    logic              burst_write_o;
    logic [31:0]       burst_addr_o;
    logic [BEAT_W-1:0] burst_wdata_o;
    logic [BEAT_W-1:0] burst_rdata_i;
    logic              burst_resp_i;

    modport slave (
        input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
        input  burst_rdata_i, burst_resp_i,
        output line_rdata_o, line_resp_o,
        output burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o
    );

    modport master (
        output line_read_i, line_write_i, line_addr_i, line_wdata_i,
        output burst_rdata_i, burst_resp_i,
        input  line_rdata_o, line_resp_o,
        input  burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o
    );
endinterface

// File: rtl/line_burst_adaptor.sv
// Converts one cache-line read/write at a time into a BEATS-beat burst on the
// physical-memory port and returns a single-cycle line response when done.
module line_burst_adaptor #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    line_burst_adaptor_if.slave  bus
);
    localparam int unsigned LineW = BEATS * BEAT_W;
    localparam int unsigned CntW  = $clog2(BEATS);
    localparam int unsigned OffW  = $clog2(LineW / 8);
    localparam logic [31:0] AddrMask = ~((32'd1 << OffW) - 32'd1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic [LineW-1:0]  r_buf;
    logic [31:0]       r_addr;
    logic              r_burst_rd;
    logic              r_burst_wr;
    logic              r_line_resp;

    logic              w_beat_last;
    logic              w_busy;

    assign w_beat_last = (r_cnt == CntW'(BEATS - 1));
    assign w_busy      = r_burst_rd | r_burst_wr;

    // Transaction FSM: latch request, count beats, fill/drain the line buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_addr      <= '0;
            r_burst_rd  <= 1'b0;
            r_burst_wr  <= 1'b0;
            r_line_resp <= 1'b0;
        end else begin
            r_line_resp <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Write has priority when both requests are present.
                    if (bus.line_write_i) begin
                        r_addr     <= bus.line_addr_i & AddrMask;
                        r_buf      <= bus.line_wdata_i;
                        r_cnt      <= '0;
                        r_burst_wr <= 1'b1;
                        r_state    <= StWr;
                    end else if (bus.line_read_i) begin
                        r_addr     <= bus.line_addr_i & AddrMask;
                        r_cnt      <= '0;
                        r_burst_rd <= 1'b1;
                        r_state    <= StRd;
                    end
                end
                StRd: begin
                    if (bus.burst_resp_i) begin
                        r_buf[r_cnt*BEAT_W +: BEAT_W] <= bus.burst_rdata_i;
                        r_cnt <= r_cnt + CntW'(1);
                        if (w_beat_last) begin
                            r_burst_rd  <= 1'b0;
                            r_line_resp <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                end
                StWr: begin
                    if (bus.burst_resp_i) begin
                        r_cnt <= r_cnt + CntW'(1);
                        if (w_beat_last) begin
                            r_burst_wr  <= 1'b0;
                            r_line_resp <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Requests are not sampled here; the next one is taken in IDLE.
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only; zero outside their phases.
    always_comb begin
        bus.burst_read_o  = r_burst_rd;
        bus.burst_write_o = r_burst_wr;
        bus.line_resp_o   = r_line_resp;
        bus.burst_addr_o  = w_busy ? r_addr : '0;
        bus.burst_wdata_o = r_burst_wr ? r_buf[r_cnt*BEAT_W +: BEAT_W] : '0;
        bus.line_rdata_o  = r_line_resp ? r_buf : '0;
    end
endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed self-checking bench for line_burst_adaptor.
module tb_line_burst_adaptor;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    line_burst_adaptor_if bus_if ();

    line_burst_adaptor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [2:0] flags;
    assign flags = {bus_if.burst_read_o, bus_if.burst_write_o, bus_if.line_resp_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; drive and sample here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line read with back-to-back beats, starting in an IDLE cycle (cycle 0).
    // Beat b returns seed*(b+1). Stray acks are driven in IDLE and DONE.
    task automatic run_read(input logic [31:0] addr, input logic [63:0] seed, input bit keep);
        logic [255:0] exp;
        exp = '0;
        bus_if.line_read_i   = 1'b1;
        bus_if.line_addr_i   = addr;
        bus_if.burst_resp_i  = 1'b1;
        bus_if.burst_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        check("rd_idle_flags", 256'(flags), 256'(3'b000));
        for (int b = 0; b < 4; b++) begin
            tick();
            check("rd_busy_flags", 256'(flags), 256'(3'b100));
            check("rd_addr", 256'(bus_if.burst_addr_o), 256'({addr[31:5], 5'b0}));
            bus_if.line_addr_i   = ~addr;
            bus_if.burst_resp_i  = 1'b1;
            bus_if.burst_rdata_i = seed * 64'(b + 1);
            exp[64*b +: 64]      = seed * 64'(b + 1);
        end
        tick();
        if (!keep) bus_if.line_read_i = 1'b0;
        bus_if.burst_rdata_i = '1;
        check("rd_done_flags", 256'(flags), 256'(3'b001));
        check("rd_line", bus_if.line_rdata_o, exp);
        tick();
        bus_if.burst_resp_i = 1'b0;
        check("rd_post_flags", 256'(flags), 256'(3'b000));
        check("rd_post_rdata", bus_if.line_rdata_o, 256'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] wline;
        logic [9:0]   ack_mask;
        int           k;

        n_checks = 0;
        n_errors = 0;

        // Reset held two cycles with a read pending.
        rst_n                = 1'b0;
        bus_if.line_read_i   = 1'b1;
        bus_if.line_write_i  = 1'b0;
        bus_if.line_addr_i   = 32'h0000_1234;
        bus_if.line_wdata_i  = '0;
        bus_if.burst_rdata_i = '0;
        bus_if.burst_resp_i  = 1'b0;
        tick();
        tick();
        check("rst_flags", 256'(flags), 256'(3'b000));
        check("rst_addr", 256'(bus_if.burst_addr_o), 256'd0);
        check("rst_wdata", 256'(bus_if.burst_wdata_o), 256'd0);
        check("rst_rdata", bus_if.line_rdata_o, 256'd0);
        rst_n = 1'b1;

        // Read 0x1234: beats 0x11..11 .. 0x44..44, address 0x1220.
        run_read(32'h0000_1234, 64'h1111_1111_1111_1111, 1'b0);

        // Write with acks on cycles 2, 5, 6, 9; inputs scrambled after acceptance.
        wline = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
                 64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
        ack_mask = 10'b10_0110_0100;
        k = 0;
        bus_if.line_write_i = 1'b1;
        bus_if.line_wdata_i = wline;
        bus_if.line_addr_i  = 32'h8000_003F;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) begin
                bus_if.line_wdata_i = ~wline;
                bus_if.line_addr_i  = 32'h0;
            end
            check("wr_flags", 256'(flags), 256'(3'b010));
            check("wr_beat", 256'(bus_if.burst_wdata_o), 256'(wline[64*k +: 64]));
            check("wr_addr", 256'(bus_if.burst_addr_o), 256'(32'h8000_0020));
            bus_if.burst_resp_i = ack_mask[c];
            if (ack_mask[c]) k++;
        end
        tick();
        bus_if.burst_resp_i = 1'b0;
        bus_if.line_write_i = 1'b0;
        check("wr_done_flags", 256'(flags), 256'(3'b001));
        check("wr_done_addr", 256'(bus_if.burst_addr_o), 256'd0);
        tick();
        check("wr_post_flags", 256'(flags), 256'(3'b000));

        // Read and write together: write wins.
        bus_if.line_read_i  = 1'b1;
        bus_if.line_write_i = 1'b1;
        bus_if.line_addr_i  = 32'h0000_0100;
        bus_if.line_wdata_i = {4{64'h5A5A_0F0F_1234_5678}};
        for (int b = 0; b < 4; b++) begin
            tick();
            check("both_flags", 256'(flags), 256'(3'b010));
            bus_if.burst_resp_i = 1'b1;
        end
        tick();
        bus_if.burst_resp_i = 1'b0;
        bus_if.line_read_i  = 1'b0;
        bus_if.line_write_i = 1'b0;
        check("both_done_flags", 256'(flags), 256'(3'b001));
        tick();
        check("both_post_flags", 256'(flags), 256'(3'b000));

        // Reset after two read beats abandons the burst.
        bus_if.line_read_i  = 1'b1;
        bus_if.line_addr_i  = 32'h0000_4040;
        tick();
        bus_if.burst_resp_i  = 1'b1;
        bus_if.burst_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        bus_if.burst_rdata_i = 64'hBAD1_BAD1_BAD1_BAD1;
        tick();
        bus_if.burst_resp_i = 1'b0;
        check("rstmid_pre_flags", 256'(flags), 256'(3'b100));
        rst_n = 1'b0;
        tick();
        check("rstmid_flags", 256'(flags), 256'(3'b000));
        check("rstmid_addr", 256'(bus_if.burst_addr_o), 256'd0);
        rst_n = 1'b1;
        run_read(32'h0000_4040, 64'h0F1E_2D3C_4B5A_6978, 1'b0);

        // Second read held through DONE is accepted only in the following IDLE.
        run_read(32'h0001_0000, 64'h0123_4567_89AB_CDEF, 1'b1);
        run_read(32'hFFFF_FFE0, 64'h1357_9BDF_2468_ACE0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
